// File: rtl/kbd_entry_ctrl_if.sv
// kbd_entry_ctrl_if: keypad entry bundle between the entry sequencer (master) and the clock core/kbd_if (slave).
interface kbd_entry_ctrl_if;
    logic [7:0]  key;
    logic        shift;
    logic        entry_active;
    logic        entry_mode;
    logic [2:0]  digit_count;
    logic [15:0] value;
    logic        load_time;
    logic        load_alarm;
    logic        entry_error;

    modport master (
        input  key,
        output shift, entry_active, entry_mode, digit_count, value,
        output load_time, load_alarm, entry_error
    );

    modport slave (
        output key,
        input  shift, entry_active, entry_mode, digit_count, value,
        input  load_time, load_alarm, entry_error
    );
endinterface

// File: rtl/kbd_entry_ctrl.sv
// kbd_entry_ctrl: collects four keypad digits after a mode key, validates HHMM and
// pulses a time/alarm load, aborting the entry after an inactivity timeout.
module kbd_entry_ctrl #(
    parameter int TIMEOUT_TICKS = 2560
) (
    input  logic clk256,
    input  logic reset,
    kbd_entry_ctrl_if.master bus
);
    localparam logic [7:0] KP_0 = 8'h70, KP_1 = 8'h69, KP_2 = 8'h72, KP_3 = 8'h7A, KP_4 = 8'h6B;
    localparam logic [7:0] KP_5 = 8'h73, KP_6 = 8'h74, KP_7 = 8'h6C, KP_8 = 8'h75, KP_9 = 8'h7D;
    localparam logic [7:0] KP_STAR = 8'h7C, KP_MINUS = 8'h7B;
    localparam logic [7:0] KP_KEY_RELEASED = 8'hF0, KP_INVALID = 8'hFF;

    typedef enum logic [1:0] {IDLE, ENTRY, CHECK} state_t;

    state_t      state_q, state_d;
    logic [7:0]  prev_key_q;
    logic [11:0] cnt_q, cnt_d;
    logic        shift_q, shift_d;
    logic        active_q, active_d;
    logic        mode_q, mode_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] value_q, value_d;
    logic        load_time_q, load_time_d;
    logic        load_alarm_q, load_alarm_d;
    logic        error_q, error_d;

    function automatic logic [4:0] decode(input logic [7:0] k);
        case (k)
            KP_0: decode = 5'h10;
            KP_1: decode = 5'h11;
            KP_2: decode = 5'h12;
            KP_3: decode = 5'h13;
            KP_4: decode = 5'h14;
            KP_5: decode = 5'h15;
            KP_6: decode = 5'h16;
            KP_7: decode = 5'h17;
            KP_8: decode = 5'h18;
            KP_9: decode = 5'h19;
            default: decode = 5'h00;
        endcase
    endfunction

    logic [4:0] dec;
    logic       ev, dig_ev, mode_ev, accepted, timeout, valid;

    // Keys are taken on the code that follows a release (F0), so a held make code never counts.
    assign dec      = decode(bus.key);
    assign ev       = prev_key_q == KP_KEY_RELEASED && bus.key != KP_KEY_RELEASED && bus.key != KP_INVALID && !shift_q;
    assign dig_ev   = ev && dec[4];
    assign mode_ev  = ev && (bus.key == KP_STAR || bus.key == KP_MINUS);
    assign accepted = dig_ev || mode_ev;
    assign timeout  = cnt_q == 12'(TIMEOUT_TICKS - 1);
    assign valid    = (value_q[15:12] < 4'd2 && value_q[11:8] <= 4'd9 || value_q[15:12] == 4'd2 && value_q[11:8] <= 4'd3)
                      && value_q[7:4] <= 4'd5 && value_q[3:0] <= 4'd9;

    always_ff @(posedge clk256 or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            prev_key_q   <= KP_KEY_RELEASED;
            cnt_q        <= '0;
            shift_q      <= 1'b0;
            active_q     <= 1'b0;
            mode_q       <= 1'b0;
            count_q      <= '0;
            value_q      <= '0;
            load_time_q  <= 1'b0;
            load_alarm_q <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            prev_key_q   <= bus.key;
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            active_q     <= active_d;
            mode_q       <= mode_d;
            count_q      <= count_d;
            value_q      <= value_d;
            load_time_q  <= load_time_d;
            load_alarm_q <= load_alarm_d;
            error_q      <= error_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (state_q == IDLE && mode_ev) state_d = ENTRY;
        if (state_q == ENTRY) state_d = (dig_ev && count_q == 3'd3) ? CHECK : (!accepted && timeout) ? IDLE : ENTRY;
        if (state_q == CHECK) state_d = IDLE;
    end

    always_comb begin
        shift_d      = 1'b0;
        load_time_d  = 1'b0;
        load_alarm_d = 1'b0;
        error_d      = 1'b0;
        mode_d       = mode_q;
        count_d      = count_q;
        value_d      = value_q;
        cnt_d        = cnt_q;
        active_d     = state_d != IDLE;
        if (mode_ev && state_q != CHECK) begin
            mode_d  = bus.key == KP_STAR;
            count_d = '0;
            value_d = '0;
            cnt_d   = '0;
        end
        if (state_q == ENTRY && dig_ev) begin
            value_d = {value_q[11:0], dec[3:0]};
            count_d = count_q + 3'd1;
            shift_d = 1'b1;
            cnt_d   = '0;
        end
        if (state_q == ENTRY && !accepted) begin
            cnt_d   = (cnt_q == 12'hFFF) ? cnt_q : cnt_q + 12'd1;
            error_d = timeout;
        end
        if (state_q == CHECK) begin
            load_alarm_d = valid && mode_q;
            load_time_d  = valid && !mode_q;
            error_d      = !valid;
        end
    end

    assign bus.shift        = shift_q;
    assign bus.entry_active = active_q;
    assign bus.entry_mode   = mode_q;
    assign bus.digit_count  = count_q;
    assign bus.value        = value_q;
    assign bus.load_time    = load_time_q;
    assign bus.load_alarm   = load_alarm_q;
    assign bus.entry_error  = error_q;
endmodule

// File: tb/tb_kbd_entry_ctrl.sv
// tb_kbd_entry_ctrl: directed scenario bench for the keypad entry sequencer.
module tb_kbd_entry_ctrl;
    localparam int TICKS = 2560;
    localparam logic [7:0] KP_STAR = 8'h7C, KP_MINUS = 8'h7B, KP_REL = 8'hF0, KP_INV = 8'hFF;
    localparam logic [7:0] KP [10] = '{8'h70, 8'h69, 8'h72, 8'h7A, 8'h6B, 8'h73, 8'h74, 8'h6C, 8'h75, 8'h7D};

    logic clk256 = 1'b0;
    logic reset  = 1'b1;
    int   pass_cnt = 0, total = 0;
    int   shift_cnt = 0, lt_cnt = 0, la_cnt = 0, err_cnt = 0, viol_cnt = 0;
    logic shift_p = 1'b0, lt_p = 1'b0, la_p = 1'b0, err_p = 1'b0;

    kbd_entry_ctrl_if bus ();
    kbd_entry_ctrl #(.TIMEOUT_TICKS(TICKS)) dut (.clk256(clk256), .reset(reset), .bus(bus));

    always #5 clk256 = ~clk256;

    // Pulse tally plus one-cycle-width and mutual-exclusion watch.
    always @(negedge clk256) begin
        shift_cnt += int'(bus.shift);
        lt_cnt    += int'(bus.load_time);
        la_cnt    += int'(bus.load_alarm);
        err_cnt   += int'(bus.entry_error);
        if ((bus.shift && shift_p) || (bus.load_time && lt_p) || (bus.load_alarm && la_p) || (bus.entry_error && err_p))
            viol_cnt++;
        if (int'(bus.load_time) + int'(bus.load_alarm) + int'(bus.entry_error) > 1) viol_cnt++;
        shift_p = bus.shift;
        lt_p    = bus.load_time;
        la_p    = bus.load_alarm;
        err_p   = bus.entry_error;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk256);
        #1;
    endtask

    task automatic send(input logic [7:0] c);
        bus.key = c;
        wait_cyc(2);
        bus.key = KP_REL;
        wait_cyc(2);
        bus.key = c;
        wait_cyc(2);
    endtask

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        else pass_cnt++;
    endtask

    task automatic test_reset();
        chk("rst_shift", 32'(bus.shift), 0);
        chk("rst_active", 32'(bus.entry_active), 0);
        chk("rst_mode", 32'(bus.entry_mode), 0);
        chk("rst_count", 32'(bus.digit_count), 0);
        chk("rst_value", 32'(bus.value), 0);
        chk("rst_lt", 32'(bus.load_time), 0);
        chk("rst_la", 32'(bus.load_alarm), 0);
        chk("rst_err", 32'(bus.entry_error), 0);
    endtask

    task automatic test_time_entry();
        int s0 = shift_cnt, t0 = lt_cnt, a0 = la_cnt;
        send(KP_MINUS);
        chk("time_active", 32'(bus.entry_active), 1);
        for (int i = 1; i <= 4; i++) send(KP[i]);
        wait_cyc(4);
        chk("time_shifts", 32'(shift_cnt - s0), 4);
        chk("time_value", 32'(bus.value), 32'h1234);
        chk("time_lt", 32'(lt_cnt - t0), 1);
        chk("time_la", 32'(la_cnt - a0), 0);
        chk("time_mode", 32'(bus.entry_mode), 0);
        chk("time_idle", 32'(bus.entry_active), 0);
    endtask

    task automatic test_alarm_repeat();
        int d[4] = '{0, 7, 0, 0};
        int t0 = lt_cnt, a0 = la_cnt, e0 = err_cnt;
        send(KP_STAR);
        chk("alm_mode", 32'(bus.entry_mode), 1);
        chk("alm_count0", 32'(bus.digit_count), 0);
        for (int i = 0; i < 4; i++) begin
            send(KP[d[i]]);
            chk($sformatf("alm_count%0d", i + 1), 32'(bus.digit_count), 32'(i + 1));
        end
        wait_cyc(4);
        chk("alm_value", 32'(bus.value), 32'h0700);
        chk("alm_la", 32'(la_cnt - a0), 1);
        chk("alm_lt", 32'(lt_cnt - t0), 0);
        chk("alm_err", 32'(err_cnt - e0), 0);
    endtask

    task automatic test_validation();
        logic [15:0] vec [3] = '{16'h2359, 16'h2400, 16'h1960};
        logic        ok  [3] = '{1'b1, 1'b0, 1'b0};
        for (int v = 0; v < 3; v++) begin
            int t0 = lt_cnt, a0 = la_cnt, e0 = err_cnt;
            logic [15:0] w = vec[v];
            send(KP_MINUS);
            for (int n = 3; n >= 0; n--) send(KP[int'(w[n*4 +: 4])]);
            wait_cyc(4);
            chk($sformatf("val_%0h_value", w), 32'(bus.value), 32'(w));
            chk($sformatf("val_%0h_lt", w), 32'(lt_cnt - t0), ok[v] ? 1 : 0);
            chk($sformatf("val_%0h_err", w), 32'(err_cnt - e0), ok[v] ? 0 : 1);
            chk($sformatf("val_%0h_la", w), 32'(la_cnt - a0), 0);
        end
    endtask

    task automatic test_timeout();
        int e0, s0, t0 = lt_cnt, a0 = la_cnt;
        send(KP_STAR);
        send(KP[1]);
        send(KP[2]);
        e0 = err_cnt;
        chk("to_open", 32'(bus.entry_active), 1);
        wait_cyc(TICKS + 40);
        chk("to_err", 32'(err_cnt - e0), 1);
        chk("to_idle", 32'(bus.entry_active), 0);
        chk("to_noload", 32'(lt_cnt - t0 + la_cnt - a0), 0);
        chk("to_value", 32'(bus.value), 32'h0012);
        s0 = shift_cnt;
        send(KP[5]);
        chk("to_noshift", 32'(shift_cnt - s0), 0);
        chk("to_count", 32'(bus.digit_count), 2);
    endtask

    task automatic test_restart_ignored();
        int e0 = err_cnt, s0;
        send(KP_MINUS);
        send(KP[1]);
        chk("rs_count1", 32'(bus.digit_count), 1);
        send(KP_STAR);
        chk("rs_count0", 32'(bus.digit_count), 0);
        chk("rs_mode", 32'(bus.entry_mode), 1);
        chk("rs_value", 32'(bus.value), 0);
        chk("rs_noerr", 32'(err_cnt - e0), 0);
        for (int i = 0; i < 4; i++) send(KP[9]);
        wait_cyc(4);
        chk("rs_bad_err", 32'(err_cnt - e0), 1);
        s0 = shift_cnt;
        bus.key = KP_REL;
        wait_cyc(2);
        bus.key = KP_INV;
        wait_cyc(2);
        send(KP[3]);
        chk("ign_noshift", 32'(shift_cnt - s0), 0);
        chk("ign_idle", 32'(bus.entry_active), 0);
    endtask

    task automatic test_reset_mid();
        int s0, t0, a0, e0;
        send(KP_MINUS);
        for (int i = 1; i <= 3; i++) send(KP[i]);
        chk("mid_count3", 32'(bus.digit_count), 3);
        #2 reset = 1'b1;
        #1;
        chk("mid_value", 32'(bus.value), 0);
        chk("mid_count", 32'(bus.digit_count), 0);
        chk("mid_active", 32'(bus.entry_active), 0);
        chk("mid_shift", 32'(bus.shift), 0);
        t0 = lt_cnt; a0 = la_cnt; e0 = err_cnt;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(2);
        s0 = shift_cnt;
        send(KP[4]);
        wait_cyc(4);
        chk("mid_noshift", 32'(shift_cnt - s0), 0);
        chk("mid_nopulse", 32'(lt_cnt - t0 + la_cnt - a0 + err_cnt - e0), 0);
        send(KP_MINUS);
        send(KP[5]);
        chk("mid_resume_count", 32'(bus.digit_count), 1);
        chk("mid_resume_shift", 32'(shift_cnt - s0), 1);
        chk("mid_resume_value", 32'(bus.value), 32'h0005);
    endtask

    initial begin
        bus.key = 8'h00;
        wait_cyc(3);
        test_reset();
        reset = 1'b0;
        wait_cyc(2);
        test_reset();
        test_time_entry();
        test_alarm_repeat();
        test_validation();
        test_timeout();
        test_restart_ignored();
        test_reset_mid();
        chk("pulse_rules", 32'(viol_cnt), 0);
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end
endmodule
